// File: rtl/iq_decimator_if.sv
// AXI-Stream bundle around the IQ decimator: 64-bit complex samples in, 32-bit packed words out.
// The slave modport is the decimator's view, the master modport is the driving environment's view.
interface iq_decimator_if #(
  parameter int S_W = 64,
  parameter int M_W = 32
);
  logic               s00_axis_tvalid;
  logic [S_W-1:0]     s00_axis_tdata;
  logic [S_W/8-1:0]   s00_axis_tstrb;
  logic               s00_axis_tlast;
  logic               s00_axis_tready;
  logic               m00_axis_tready;
  logic               m00_axis_tvalid;
  logic [M_W-1:0]     m00_axis_tdata;
  logic [M_W/8-1:0]   m00_axis_tstrb;
  logic               m00_axis_tlast;

  modport slave (
    input  s00_axis_tvalid, s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast, m00_axis_tready,
    output s00_axis_tready, m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast
  );

  modport master (
    output s00_axis_tvalid, s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast, m00_axis_tready,
    input  s00_axis_tready, m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast
  );
endinterface

// File: rtl/iq_decimator.sv
// Integrate-and-dump decimator: sums DECIM complex samples, shifts, saturates to 16 bits per
// component and emits one {imag16, real16} word per group; tlast forces an early dump.
module iq_decimator #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 64,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int DECIM                  = 8,
  parameter int SHIFT                  = 3
) (
  input  logic        s00_axis_aclk,
  input  logic        s00_axis_areset,
  iq_decimator_if.slave axis
);
  localparam int IN_W  = C_S00_AXIS_TDATA_WIDTH / 2;
  localparam int OUT_W = C_M00_AXIS_TDATA_WIDTH / 2;
  localparam int CNT_W = $clog2(DECIM);
  localparam int ACC_W = IN_W + $clog2(DECIM);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

  logic [CNT_W-1:0]                  cnt_q;
  logic                              tvalid_q;
  logic                              tlast_q;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] tdata_q;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] word_d;
  logic                              in_ready;
  logic                              in_hs;
  logic                              dump;
  logic                              unused_tstrb;

  // One-entry output register: accept input whenever that register is free or draining.
  assign in_ready = ~tvalid_q | axis.m00_axis_tready;
  assign in_hs    = axis.s00_axis_tvalid & in_ready;
  assign dump     = in_hs & ((cnt_q == CNT_W'(DECIM - 1)) | axis.s00_axis_tlast);

  assign unused_tstrb = ^axis.s00_axis_tstrb;

  for (genvar gi = 0; gi < 2; gi++) begin : g_comp
    logic signed [IN_W-1:0]  sample;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] sum_d;
    logic signed [ACC_W-1:0] shifted_d;
    logic [OUT_W-1:0]        sat_d;

    assign sample    = axis.s00_axis_tdata[gi*IN_W +: IN_W];
    assign sum_d     = acc_q + ACC_W'(sample);
    // Arithmetic shift floors toward -inf; no rounding offset by design.
    assign shifted_d = sum_d >>> SHIFT;
    assign sat_d     = (shifted_d > SAT_MAX) ? OUT_W'(SAT_MAX) :
                       (shifted_d < SAT_MIN) ? OUT_W'(SAT_MIN) :
                       shifted_d[OUT_W-1:0];
    assign word_d[gi*OUT_W +: OUT_W] = sat_d;

    always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
        acc_q <= '0;
      end else if (in_hs) begin
        acc_q <= dump ? '0 : sum_d;
      end
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      if (in_hs) begin
        if (dump) begin
          cnt_q   <= '0;
          tdata_q <= word_d;
          tlast_q <= axis.s00_axis_tlast;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      // A dump in the same cycle as a drain reloads the register, so tvalid only drops without one.
      if (dump) begin
        tvalid_q <= 1'b1;
      end else if (tvalid_q && axis.m00_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign axis.s00_axis_tready = in_ready;
  assign axis.m00_axis_tvalid = tvalid_q;
  assign axis.m00_axis_tdata  = tdata_q;
  assign axis.m00_axis_tlast  = tlast_q;
  assign axis.m00_axis_tstrb  = '1;
endmodule

// File: tb/tb_iq_decimator.sv
// Directed bench for iq_decimator: two instances (SHIFT=2 and SHIFT=0, DECIM=4) share one input
// stream; each transaction prints one line and the run ends with a single summary line.
module tb_iq_decimator;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] got_q[$];

  iq_decimator_if #(.S_W(64), .M_W(32)) ifs2 ();
  iq_decimator_if #(.S_W(64), .M_W(32)) ifs0 ();

  assign ifs0.s00_axis_tvalid = ifs2.s00_axis_tvalid;
  assign ifs0.s00_axis_tdata  = ifs2.s00_axis_tdata;
  assign ifs0.s00_axis_tstrb  = ifs2.s00_axis_tstrb;
  assign ifs0.s00_axis_tlast  = ifs2.s00_axis_tlast;
  assign ifs0.m00_axis_tready = ifs2.m00_axis_tready;

  iq_decimator #(.C_S00_AXIS_TDATA_WIDTH(64), .C_M00_AXIS_TDATA_WIDTH(32), .DECIM(4), .SHIFT(2)) u_s2 (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .axis            (ifs2)
  );

  iq_decimator #(.C_S00_AXIS_TDATA_WIDTH(64), .C_M00_AXIS_TDATA_WIDTH(32), .DECIM(4), .SHIFT(0)) u_s0 (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .axis            (ifs0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every word accepted downstream from the SHIFT=2 instance.
  always @(posedge clk) begin
    if (ifs2.m00_axis_tvalid && ifs2.m00_axis_tready) got_q.push_back(ifs2.m00_axis_tdata);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] re, input logic [31:0] im, input logic last);
    bit ok;
    ok = 1'b0;
    ifs2.s00_axis_tvalid = 1'b1;
    ifs2.s00_axis_tdata  = {im, re};
    ifs2.s00_axis_tlast  = last;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = ifs2.s00_axis_tready;
      @(posedge clk);
      #1;
    end
    if (!ok) check_eq("push_timeout", 32'd0, 32'd1);
    ifs2.s00_axis_tvalid = 1'b0;
    ifs2.s00_axis_tlast  = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_words [3];
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    ifs2.s00_axis_tvalid = 1'b0;
    ifs2.s00_axis_tdata  = '0;
    ifs2.s00_axis_tstrb  = 8'hFF;
    ifs2.s00_axis_tlast  = 1'b0;
    ifs2.m00_axis_tready = 1'b1;
    repeat (3) idle();
    rst = 1'b0;

    check_eq("rst_tvalid", {31'd0, ifs2.m00_axis_tvalid}, 32'd0);
    check_eq("rst_tdata",  ifs2.m00_axis_tdata, 32'd0);
    check_eq("rst_tlast",  {31'd0, ifs2.m00_axis_tlast}, 32'd0);
    check_eq("rst_sready", {31'd0, ifs2.s00_axis_tready}, 32'd1);
    check_eq("tstrb",      {28'd0, ifs2.m00_axis_tstrb}, 32'h0000_000F);

    // Basic group: 4x {-50, 100}
    for (int i = 0; i < 3; i++) push(32'd100, -32'sd50, 1'b0);
    check_eq("basic_no_early", {31'd0, ifs2.m00_axis_tvalid}, 32'd0);
    push(32'd100, -32'sd50, 1'b0);
    check_eq("basic_tvalid", {31'd0, ifs2.m00_axis_tvalid}, 32'd1);
    check_eq("basic_s2",     ifs2.m00_axis_tdata, 32'hFFCE_0064);
    check_eq("basic_s0",     ifs0.m00_axis_tdata, 32'hFF38_0190);
    check_eq("basic_tlast",  {31'd0, ifs2.m00_axis_tlast}, 32'd0);
    idle();
    check_eq("basic_drained", {31'd0, ifs2.m00_axis_tvalid}, 32'd0);

    // Saturation in both directions
    for (int i = 0; i < 4; i++) push(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    check_eq("sat_s0", ifs0.m00_axis_tdata, 32'h8000_7FFF);
    check_eq("sat_s2", ifs2.m00_axis_tdata, 32'h8000_7FFF);
    idle();

    // Early dump on tlast, then a full group restarted from phase 0
    push(32'd8, 32'd0, 1'b0);
    push(32'd8, 32'd0, 1'b1);
    check_eq("tlast_word",  ifs2.m00_axis_tdata, 32'h0000_0004);
    check_eq("tlast_flag",  {31'd0, ifs2.m00_axis_tlast}, 32'd1);
    push(32'd1, 32'd0, 1'b0);
    push(32'd2, 32'd0, 1'b0);
    push(32'd3, 32'd0, 1'b0);
    check_eq("restart_no_early", {31'd0, ifs2.m00_axis_tvalid}, 32'd0);
    push(32'd4, 32'd0, 1'b0);
    check_eq("restart_word", ifs2.m00_axis_tdata, 32'h0000_0002);
    check_eq("restart_tlast", {31'd0, ifs2.m00_axis_tlast}, 32'd0);
    idle();

    // Floor behaviour of the arithmetic shift
    push(32'hFFFF_FFFF, 32'd0, 1'b1);
    check_eq("floor_neg", ifs2.m00_axis_tdata, 32'h0000_FFFF);
    for (int i = 0; i < 4; i++) push(32'd1, 32'd0, 1'b0);
    check_eq("floor_pos", ifs2.m00_axis_tdata, 32'h0000_0001);
    idle();

    // Backpressure: word A held, B stalled, then A/B/C delivered in order
    got_q.delete();
    ifs2.m00_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'd4, 32'd8, 1'b0);
    check_eq("bp_a_word",  ifs2.m00_axis_tdata, 32'h0008_0004);
    check_eq("bp_sready0", {31'd0, ifs2.s00_axis_tready}, 32'd0);
    ifs2.s00_axis_tvalid = 1'b1;
    ifs2.s00_axis_tdata  = {32'hFFFF_FFFC, 32'd20};
    for (int i = 0; i < 3; i++) begin
      idle();
      check_eq("bp_hold_data",  ifs2.m00_axis_tdata, 32'h0008_0004);
      check_eq("bp_hold_valid", {31'd0, ifs2.m00_axis_tvalid}, 32'd1);
    end
    ifs2.m00_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) push(32'd20, 32'hFFFF_FFFC, 1'b0);
    check_eq("bp_b_word", ifs2.m00_axis_tdata, 32'hFFFC_0014);
    push(32'd12, 32'd0, 1'b1);
    check_eq("bp_c_valid", {31'd0, ifs2.m00_axis_tvalid}, 32'd1);
    check_eq("bp_c_word",  ifs2.m00_axis_tdata, 32'h0000_0003);
    check_eq("bp_c_tlast", {31'd0, ifs2.m00_axis_tlast}, 32'd1);
    idle();
    check_eq("bp_count", got_q.size(), 32'd3);
    exp_words[0] = 32'h0008_0004;
    exp_words[1] = 32'hFFFC_0014;
    exp_words[2] = 32'h0000_0003;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("bp_order%0d", i), (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF, exp_words[i]);
    end

    // Reset mid-accumulation discards the partial sum
    push(32'd1000, 32'd0, 1'b0);
    push(32'd1000, 32'd0, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check_eq("midrst_tvalid", {31'd0, ifs2.m00_axis_tvalid}, 32'd0);
    for (int i = 0; i < 4; i++) push(32'd4, 32'd0, 1'b0);
    check_eq("midrst_s2", ifs2.m00_axis_tdata, 32'h0000_0004);
    check_eq("midrst_s0", ifs0.m00_axis_tdata, 32'h0000_0010);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
